// File: rtl/egg_timer_multi.sv
// Multi-channel MM:SS countdown timer sharing one 1 Hz prescaler and one BCD display port.
// Define PRESET_RECALL_EN to keep a per-channel preset that start/stop reload from DONE.
module egg_timer_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CLK_HZ   = 5000000,
  parameter int unsigned MAX_MINS = 99
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  enable,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    sel,
  input  logic                                                  cook_time,
  input  logic                                                  start,
  input  logic                                                  stop,
  input  logic                                                  mins,
  input  logic                                                  secs,
  output logic [15:0]                                           time_bcd,
  output logic [CHANNELS-1:0]                                   running,
  output logic [CHANNELS-1:0]                                   done,
  output logic                                                  led_en
);

  localparam int unsigned SelW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned MaxSecs = MAX_MINS * 60 + 59;
  localparam int unsigned CntW    = $clog2(MaxSecs + 1);
  localparam int unsigned PrescW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [CntW-1:0]   MaxCnt    = CntW'(MaxSecs);
  localparam logic [CntW-1:0]   SecPerMin = CntW'(60);
  localparam logic [CntW-1:0]   Ten       = CntW'(10);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_HZ - 1);

  typedef enum logic [2:0] {StIdle, StConfig, StPause, StRun, StDone} state_e;

  state_e              state_q [CHANNELS];
  logic [CntW-1:0]     count_q [CHANNELS];
  logic [CHANNELS-1:0] done_q;
`ifdef PRESET_RECALL_EN
  logic [CntW-1:0]     preset_q [CHANNELS];
`endif

  logic [PrescW-1:0]   presc_q;
  logic                tick;
  logic [CHANNELS-1:0] is_sel;
  logic [CntW:0]       cfg_sum [CHANNELS];
  logic [CntW-1:0]     disp_cnt, disp_min, disp_sec;
  logic [3:0]          min_tens, min_ones, sec_tens, sec_ones;
  logic [15:0]         time_bcd_q;
  logic                led_en_q;

  // Free-running prescaler; tick is high during the last cycle of each period.
  assign tick = (presc_q == PrescLast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PrescW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      is_sel[i]  = (sel == SelW'(i));
      cfg_sum[i] = {1'b0, count_q[i]} + (mins ? {1'b0, SecPerMin} : '0)
                   + {{CntW{1'b0}}, secs};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= StIdle;
        count_q[i]  <= '0;
`ifdef PRESET_RECALL_EN
        preset_q[i] <= '0;
`endif
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (is_sel[i] && cook_time && enable) begin
          if (state_q[i] != StConfig) begin
            state_q[i] <= StConfig;
            done_q[i]  <= 1'b0;
          end else begin
            count_q[i] <= (cfg_sum[i] > {1'b0, MaxCnt}) ? MaxCnt : cfg_sum[i][CntW-1:0];
          end
        end else begin
          unique case (state_q[i])
            StConfig: begin
              state_q[i]  <= (count_q[i] != '0) ? StPause : StIdle;
`ifdef PRESET_RECALL_EN
              preset_q[i] <= count_q[i];
`endif
            end
            StPause: begin
              if (is_sel[i] && start && enable && (count_q[i] != '0)) begin
                state_q[i] <= StRun;
              end
            end
            StRun: begin
              // Pausing wins over a coincident tick so the count stays exactly frozen.
              if (!enable || (is_sel[i] && stop)) begin
                state_q[i] <= StPause;
              end else if (tick) begin
                count_q[i] <= count_q[i] - CntW'(1);
                if (count_q[i] == CntW'(1)) begin
                  state_q[i] <= StDone;
                  done_q[i]  <= 1'b1;
                end
              end
            end
            StDone: begin
              if (is_sel[i] && stop) begin
                done_q[i]  <= 1'b0;
`ifdef PRESET_RECALL_EN
                count_q[i] <= preset_q[i];
                state_q[i] <= (preset_q[i] != '0) ? StPause : StIdle;
`else
                count_q[i] <= '0;
                state_q[i] <= StIdle;
`endif
              end
`ifdef PRESET_RECALL_EN
              else if (is_sel[i] && start && enable) begin
                done_q[i]  <= 1'b0;
                count_q[i] <= preset_q[i];
                state_q[i] <= (preset_q[i] != '0) ? StRun : StIdle;
              end
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Display path: pick the selected count, split into MM:SS, then into BCD digits.
  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (is_sel[i]) begin
        disp_cnt = count_q[i];
      end
    end
  end

  assign disp_min = disp_cnt / SecPerMin;
  assign disp_sec = disp_cnt % SecPerMin;
  assign min_tens = 4'(disp_min / Ten);
  assign min_ones = 4'(disp_min % Ten);
  assign sec_tens = 4'(disp_sec / Ten);
  assign sec_ones = 4'(disp_sec % Ten);

  always_ff @(posedge clk) begin
    if (!rst) begin
      time_bcd_q <= '0;
      led_en_q   <= 1'b0;
    end else begin
      time_bcd_q <= {min_tens, min_ones, sec_tens, sec_ones};
      led_en_q   <= enable;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      running[i] = (state_q[i] == StRun);
    end
  end

  assign done     = done_q;
  assign time_bcd = time_bcd_q;
  assign led_en   = led_en_q;

endmodule

// File: tb/tb_egg_timer_multi.sv
// Directed bench for egg_timer_multi at CLK_HZ=10, CHANNELS=4; define PRESET_RECALL_EN to
// exercise the preset build.
module tb_egg_timer_multi;

  logic        clk = 1'b0;
  logic        rst, enable, cook_time, start, stop, mins, secs;
  logic [1:0]  sel;
  logic [15:0] time_bcd;
  logic [3:0]  running, done;
  logic        led_en;

  int total = 0;
  int bad   = 0;

  egg_timer_multi #(
    .CHANNELS(4),
    .CLK_HZ  (10),
    .MAX_MINS(99)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sel      (sel),
    .cook_time(cook_time),
    .start    (start),
    .stop     (stop),
    .mins     (mins),
    .secs     (secs),
    .time_bcd (time_bcd),
    .running  (running),
    .done     (done),
    .led_en   (led_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; sel = 2'd0; cook_time = 1'b0;
    start = 1'b0; stop = 1'b0; mins = 1'b0; secs = 1'b0;
    step();
    rst = 1'b1; enable = 1'b1;
    step();
  endtask

  task automatic cfg(input logic [1:0] ch, input int nm, input int ns);
    sel = ch; cook_time = 1'b1;
    step();
    for (int k = 0; k < nm; k++) begin mins = 1'b1; step(); mins = 1'b0; end
    for (int k = 0; k < ns; k++) begin secs = 1'b1; step(); secs = 1'b0; end
    cook_time = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_start(input logic [1:0] ch);
    sel = ch; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop(input logic [1:0] ch);
    sel = ch; stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL rst_bcd: got %h want 0000", time_bcd); end
    total++; if (running !== 4'b0000) begin bad++; $display("FAIL rst_running: got %b want 0000", running); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL rst_done: got %b want 0000", done); end
    total++; if (led_en !== 1'b1) begin bad++; $display("FAIL led_en_copy: got %b want 1", led_en); end
    rst = 1'b0;
    step();
    total++; if (led_en !== 1'b0) begin bad++; $display("FAIL rst_led_en: got %b want 0", led_en); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_config();
    do_reset();
    cfg(2'd0, 2, 5);
    total++; if (time_bcd !== 16'h0205) begin bad++; $display("FAIL cfg_0205: got %h want 0205", time_bcd); end
    total++; if (running !== 4'b0000) begin bad++; $display("FAIL cfg_running: got %b want 0000", running); end
    // mins and secs together in one cycle
    sel = 2'd1; cook_time = 1'b1; step();
    mins = 1'b1; secs = 1'b1; step(); mins = 1'b0; secs = 1'b0;
    cook_time = 1'b0; step(); step();
    total++; if (time_bcd !== 16'h0101) begin bad++; $display("FAIL cfg_61s: got %h want 0101", time_bcd); end
    sel = 2'd0;
    total++; if (time_bcd !== 16'h0101) begin bad++; $display("FAIL sel_latency_hold: got %h want 0101", time_bcd); end
    step();
    total++; if (time_bcd !== 16'h0205) begin bad++; $display("FAIL sel_latency_upd: got %h want 0205", time_bcd); end
    // moving sel away ends CONFIG for the channel left behind
    sel = 2'd2; cook_time = 1'b1; step();
    secs = 1'b1; step(); step(); step(); secs = 1'b0;
    sel = 2'd3; step(); cook_time = 1'b0; step();
    pulse_start(2'd2);
    total++; if (running !== 4'b0100) begin bad++; $display("FAIL sel_away_pause: got %b want 0100", running); end
    pulse_start(2'd0);
    total++; if (running !== 4'b0101) begin bad++; $display("FAIL cfg_pause_start: got %b want 0101", running); end
  endtask

  task automatic test_start_expire();
    do_reset();
    pulse_start(2'd2);
    total++; if (running[2] !== 1'b0) begin bad++; $display("FAIL idle_start: got %b want 0", running[2]); end
    cfg(2'd0, 0, 3);
    total++; if (time_bcd !== 16'h0003) begin bad++; $display("FAIL cfg_0003: got %h want 0003", time_bcd); end
    pulse_start(2'd0);
    total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL run_start: got %b want 1", running[0]); end
    repeat (19) step();
    total++; if (done[0] !== 1'b0) begin bad++; $display("FAIL early_done: got %b want 0", done[0]); end
    repeat (12) step();
    total++; if (done[0] !== 1'b1) begin bad++; $display("FAIL expire_done: got %b want 1", done[0]); end
    total++; if (running[0] !== 1'b0) begin bad++; $display("FAIL expire_running: got %b want 0", running[0]); end
    total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL expire_bcd: got %h want 0000", time_bcd); end
  endtask

  task automatic test_stop_resume();
    do_reset();
    cfg(2'd1, 1, 0);
    pulse_start(2'd1);
    pulse_stop(2'd1);
    total++; if (running[1] !== 1'b0) begin bad++; $display("FAIL stop_pause: got %b want 0", running[1]); end
    repeat (30) step();
    total++;
    if (time_bcd !== 16'h0100 && time_bcd !== 16'h0059) begin
      bad++; $display("FAIL stop_frozen: got %h want 0100 or 0059", time_bcd);
    end
    pulse_start(2'd1);
    total++; if (running[1] !== 1'b1) begin bad++; $display("FAIL stop_resume: got %b want 1", running[1]); end
  endtask

  task automatic test_saturate();
    do_reset();
    cfg(2'd0, 100, 0);
    total++; if (time_bcd !== 16'h9959) begin bad++; $display("FAIL sat_mins: got %h want 9959", time_bcd); end
    cfg(2'd0, 0, 1);
    total++; if (time_bcd !== 16'h9959) begin bad++; $display("FAIL sat_secs: got %h want 9959", time_bcd); end
  endtask

  task automatic test_enable();
    do_reset();
    cfg(2'd0, 0, 50);
    cfg(2'd2, 0, 40);
    pulse_start(2'd0);
    pulse_start(2'd2);
    total++; if (running !== 4'b0101) begin bad++; $display("FAIL en_both_run: got %b want 0101", running); end
    enable = 1'b0;
    step();
    total++; if (running !== 4'b0000) begin bad++; $display("FAIL en_pause: got %b want 0000", running); end
    total++; if (led_en !== 1'b0) begin bad++; $display("FAIL en_led: got %b want 0", led_en); end
    // start, mins and cook_time must all be ignored while disabled
    sel = 2'd0; start = 1'b1; cook_time = 1'b1; mins = 1'b1;
    step();
    start = 1'b0; cook_time = 1'b0; mins = 1'b0;
    repeat (50) step();
    total++; if (running !== 4'b0000) begin bad++; $display("FAIL en_start_ign: got %b want 0000", running); end
    total++;
    if (time_bcd !== 16'h0050 && time_bcd !== 16'h0049) begin
      bad++; $display("FAIL en_freeze_ch0: got %h want 0050 or 0049", time_bcd);
    end
    sel = 2'd2; step(); step();
    total++;
    if (time_bcd !== 16'h0040 && time_bcd !== 16'h0039) begin
      bad++; $display("FAIL en_freeze_ch2: got %h want 0040 or 0039", time_bcd);
    end
    enable = 1'b1;
    step();
    pulse_start(2'd0);
    pulse_start(2'd2);
    total++; if (running !== 4'b0101) begin bad++; $display("FAIL en_resume: got %b want 0101", running); end
    repeat (30) step();
    sel = 2'd0;
    step();
    total++;
    if (time_bcd < 16'h0045 || time_bcd > 16'h0047) begin
      bad++; $display("FAIL en_resume_count: got %h want 0045..0047", time_bcd);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    cfg(2'd1, 1, 0);
    pulse_start(2'd1);
    repeat (3) step();
    rst = 1'b0;
    step();
    total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL mid_rst_bcd: got %h want 0000", time_bcd); end
    total++; if (running !== 4'b0000) begin bad++; $display("FAIL mid_rst_running: got %b want 0000", running); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL mid_rst_done: got %b want 0000", done); end
    total++; if (led_en !== 1'b0) begin bad++; $display("FAIL mid_rst_led: got %b want 0", led_en); end
    rst = 1'b1;
    step();
    pulse_start(2'd1);
    step();
    total++; if (running[1] !== 1'b0) begin bad++; $display("FAIL mid_rst_idle: got %b want 0", running[1]); end
    total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL mid_rst_count: got %h want 0000", time_bcd); end
  endtask

  task automatic test_prescaler();
    int n;
    do_reset();
    cfg(2'd3, 1, 0);
    pulse_start(2'd3);
    n = 0;
    while (time_bcd == 16'h0100 && n < 30) begin step(); n++; end
    total++; if (time_bcd !== 16'h0059) begin bad++; $display("FAIL tick_first: got %h want 0059", time_bcd); end
    n = 0;
    while (time_bcd == 16'h0059 && n < 30) begin step(); n++; end
    total++; if (n != 10) begin bad++; $display("FAIL tick_period: got %0d want 10", n); end
  endtask

  task automatic test_preset();
    int n;
    do_reset();
    cfg(2'd1, 0, 10);
    total++; if (time_bcd !== 16'h0010) begin bad++; $display("FAIL pre_cfg: got %h want 0010", time_bcd); end
    pulse_start(2'd1);
    n = 0;
    while (done[1] !== 1'b1 && n < 130) begin step(); n++; end
    total++; if (done[1] !== 1'b1) begin bad++; $display("FAIL pre_expire: got %b want 1", done[1]); end
    step();
    total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL pre_zero: got %h want 0000", time_bcd); end
    pulse_start(2'd1);
`ifdef PRESET_RECALL_EN
    total++; if (running[1] !== 1'b1) begin bad++; $display("FAIL pre_rerun: got %b want 1", running[1]); end
    total++; if (done[1] !== 1'b0) begin bad++; $display("FAIL pre_done_clr: got %b want 0", done[1]); end
    step();
    total++; if (time_bcd !== 16'h0010) begin bad++; $display("FAIL pre_reload: got %h want 0010", time_bcd); end
`else
    total++; if (running[1] !== 1'b0) begin bad++; $display("FAIL done_start_ign: got %b want 0", running[1]); end
    total++; if (done[1] !== 1'b1) begin bad++; $display("FAIL done_sticky: got %b want 1", done[1]); end
    pulse_stop(2'd1);
    total++; if (done[1] !== 1'b0) begin bad++; $display("FAIL done_stop_clr: got %b want 0", done[1]); end
    step();
    total++; if (time_bcd !== 16'h0000) begin bad++; $display("FAIL done_stop_bcd: got %h want 0000", time_bcd); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_config();
    test_start_expire();
    test_stop_resume();
    test_saturate();
    test_enable();
    test_reset_midrun();
    test_prescaler();
    test_preset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
